// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the instruction/data memory port arbiter:
// FSM state encoding, d_size encodings, grant encoding and the default
// refill burst length.
package mem_port_arbiter_pkg;

    localparam int unsigned LINE_WORDS_DEF = 8;

    // d_size / mem_size encodings
    localparam logic [1:0] SIZE_WORD = 2'd0;
    localparam logic [1:0] SIZE_BYTE = 2'd1;
    localparam logic [1:0] SIZE_HALF = 2'd2;
    localparam logic [1:0] SIZE_TRI  = 2'd3;

    // Grant / last_grant encoding
    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        I_RD,
        D_RD,
        D_WR,
        RESP
    } state_t;

endpackage

// File: rtl/mem_arb_rr2.sv
// Two-way round-robin grant between the instruction and data requesters.
// Ports:
//   i_req, d_req : pending requests
//   last_grant   : requester granted most recently (GNT_I / GNT_D)
//   grant        : selected requester; only meaningful when a request exists
module mem_arb_rr2
    import mem_port_arbiter_pkg::*;
(
    input  logic i_req,
    input  logic d_req,
    input  logic last_grant,
    output logic grant
);

    always_comb begin
        grant = GNT_I;
        if (i_req && d_req) begin
            // conflict: the side not served last time wins
            grant = ~last_grant;
        end else if (d_req) begin
            grant = GNT_D;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single memory port between an instruction-refill requester
// and a data requester (line refills and single stores).
// Ports:
//   CLK, RESET             : clock, asynchronous active-high reset
//   i_req/i_addr           : I-side line refill request and address
//   i_rdata/i_rvalid/i_done: I-side returned beats and burst completion
//   d_req/d_we/d_addr/d_wdata/d_size : D-side request (store or refill)
//   d_rdata/d_rvalid/d_done: D-side returned beats / completion
//   mem_*                  : shared memory port, one beat per mem_ack
//   busy                   : high whenever the arbiter is not idle
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned LINE_WORDS = LINE_WORDS_DEF
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_rvalid,
    output logic        i_done,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [1:0]  d_size,
    output logic [31:0] d_rdata,
    output logic        d_rvalid,
    output logic        d_done,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [1:0]  mem_size,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        busy
);

    localparam int unsigned BW = $clog2(LINE_WORDS);
    localparam logic [BW-1:0] LAST_BEAT = BW'(LINE_WORDS - 1);

    state_t         state;
    logic [BW-1:0]  beat;
    logic           last_grant;
    logic           grant;
    logic [31:0]    lat_addr;
    logic           lat_we;
    logic [31:0]    lat_wdata;
    logic [1:0]     lat_size;
    logic           mem_req_q;
    logic           busy_q;

    mem_arb_rr2 u_rr (
        .i_req      (i_req),
        .d_req      (d_req),
        .last_grant (last_grant),
        .grant      (grant)
    );

    // mem_req and busy are registered alongside the state, so each branch
    // sets them to the value that matches the state being entered.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state      <= IDLE;
            beat       <= '0;
            last_grant <= GNT_I;
            lat_addr   <= '0;
            lat_we     <= 1'b0;
            lat_wdata  <= '0;
            lat_size   <= '0;
            mem_req_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_req || d_req) begin
                        last_grant <= grant;
                        beat       <= '0;
                        mem_req_q  <= 1'b1;
                        busy_q     <= 1'b1;
                        if (grant == GNT_D) begin
                            lat_addr  <= d_addr;
                            lat_we    <= d_we;
                            lat_wdata <= d_wdata;
                            lat_size  <= d_size;
                            state     <= d_we ? D_WR : D_RD;
                        end else begin
                            lat_addr  <= i_addr;
                            lat_we    <= 1'b0;
                            lat_size  <= SIZE_WORD;
                            state     <= I_RD;
                        end
                    end
                end
                I_RD, D_RD: begin
                    if (mem_ack) begin
                        if (beat == LAST_BEAT) begin
                            beat      <= '0;
                            state     <= RESP;
                            mem_req_q <= 1'b0;
                        end else begin
                            beat <= beat + 1'b1;
                        end
                    end
                end
                D_WR: begin
                    if (mem_ack) begin
                        state     <= RESP;
                        mem_req_q <= 1'b0;
                    end
                end
                RESP: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    mem_req_q <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    logic rd_state;
    logic final_ack;

    assign rd_state  = (state == I_RD) || (state == D_RD);
    assign final_ack = mem_ack && (beat == LAST_BEAT);

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_size  = SIZE_WORD;
        mem_we    = 1'b0;
        i_rdata   = '0;
        i_rvalid  = 1'b0;
        i_done    = 1'b0;
        d_rdata   = '0;
        d_rvalid  = 1'b0;
        d_done    = 1'b0;
        if (rd_state) begin
            // line-aligned base with the beat index in the word field
            mem_addr = {lat_addr[31:BW+2], beat, 2'b00};
        end
        case (state)
            I_RD: begin
                i_rdata  = mem_rdata;
                i_rvalid = mem_ack;
                i_done   = final_ack;
            end
            D_RD: begin
                d_rdata  = mem_rdata;
                d_rvalid = mem_ack;
                d_done   = final_ack;
            end
            D_WR: begin
                mem_we    = lat_we;
                mem_addr  = lat_addr;
                mem_wdata = lat_wdata;
                mem_size  = lat_size;
                d_done    = mem_ack;
            end
            default: ;
        endcase
    end

    assign mem_req = mem_req_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (LINE_WORDS = 8).
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_rvalid;
    logic        i_done;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [1:0]  d_size;
    logic [31:0] d_rdata;
    logic        d_rvalid;
    logic        d_done;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [1:0]  mem_size;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        busy;

    int total = 0;
    int bad   = 0;

    mem_port_arbiter #(.LINE_WORDS(8)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_rdata   (i_rdata),
        .i_rvalid  (i_rvalid),
        .i_done    (i_done),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_size    (d_size),
        .d_rdata   (d_rdata),
        .d_rvalid  (d_rvalid),
        .d_done    (d_done),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_size  (mem_size),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .busy      (busy)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mem_req"},   32'(mem_req),   32'd0);
        chk({tag, "_mem_we"},    32'(mem_we),    32'd0);
        chk({tag, "_mem_addr"},  mem_addr,       32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata,      32'd0);
        chk({tag, "_mem_size"},  32'(mem_size),  32'd0);
        chk({tag, "_i_rdata"},   i_rdata,        32'd0);
        chk({tag, "_d_rdata"},   d_rdata,        32'd0);
        chk({tag, "_i_rvalid"},  32'(i_rvalid),  32'd0);
        chk({tag, "_d_rvalid"},  32'(d_rvalid),  32'd0);
        chk({tag, "_i_done"},    32'(i_done),    32'd0);
        chk({tag, "_d_done"},    32'(d_done),    32'd0);
        chk({tag, "_busy"},      32'(busy),      32'd0);
    endtask

    // Expects the arbiter at beat 0 of a read burst; acks every cycle and
    // leaves it in RESP with mem_ack still high.
    task automatic run_burst(input string tag, input bit dside, input logic [31:0] base);
        for (int b = 0; b < 8; b++) begin
            mem_ack   = 1'b1;
            mem_rdata = 32'hC0DE_0000 + 32'(b);
            #1;
            chk({tag, "_addr"}, mem_addr, base + 32'(4 * b));
            chk({tag, "_req"},  32'(mem_req), 32'd1);
            chk({tag, "_we"},   32'(mem_we),  32'd0);
            if (dside) begin
                chk({tag, "_d_rvalid"}, 32'(d_rvalid), 32'd1);
                chk({tag, "_i_rvalid"}, 32'(i_rvalid), 32'd0);
                chk({tag, "_d_rdata"},  d_rdata, 32'hC0DE_0000 + 32'(b));
                chk({tag, "_d_done"},   32'(d_done), (b == 7) ? 32'd1 : 32'd0);
            end else begin
                chk({tag, "_i_rvalid"}, 32'(i_rvalid), 32'd1);
                chk({tag, "_d_rvalid"}, 32'(d_rvalid), 32'd0);
                chk({tag, "_i_rdata"},  i_rdata, 32'hC0DE_0000 + 32'(b));
                chk({tag, "_i_done"},   32'(i_done), (b == 7) ? 32'd1 : 32'd0);
            end
            tick();
        end
    endtask

    task automatic chk_resp(input string tag);
        #1;
        chk({tag, "_resp_req"},    32'(mem_req),  32'd0);
        chk({tag, "_resp_busy"},   32'(busy),     32'd1);
        chk({tag, "_resp_ivalid"}, 32'(i_rvalid), 32'd0);
        chk({tag, "_resp_dvalid"}, 32'(d_rvalid), 32'd0);
        chk({tag, "_resp_idone"},  32'(i_done),   32'd0);
        chk({tag, "_resp_ddone"},  32'(d_done),   32'd0);
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        #1;
        chk_all_zero("rst");
        tick();
        tick();
        RESET = 1'b0;
    endtask

    initial begin
        int b;
        RESET     = 1'b1;
        i_req     = 1'b0;
        i_addr    = '0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_addr    = '0;
        d_wdata   = '0;
        d_size    = SIZE_WORD;
        mem_rdata = 32'hFFFF_FFFF;
        mem_ack   = 1'b1;

        // reset state, with mem_ack and mem_rdata held non-zero
        do_reset();
        #1;
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_req",  32'(mem_req), 32'd0);
        mem_ack = 1'b0;

        // lone I refill from 0x1234
        i_req  = 1'b1;
        i_addr = 32'h0000_1234;
        tick();
        chk("t1_busy", 32'(busy), 32'd1);
        run_burst("t1", 1'b0, 32'h0000_1220);
        chk_resp("t1");
        i_req = 1'b0;
        tick();
        chk("t1_idle_busy", 32'(busy), 32'd0);
        mem_ack = 1'b0;

        // simultaneous requests after reset: D first, then I, then D again
        do_reset();
        i_req  = 1'b1;
        i_addr = 32'h0000_0100;
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h4000_0048;
        tick();
        run_burst("t2_d1", 1'b1, 32'h4000_0040);
        chk_resp("t2_d1");
        d_req = 1'b0;
        tick();
        #1;
        chk("t2_idle_busy", 32'(busy), 32'd0);
        tick();
        run_burst("t2_i", 1'b0, 32'h0000_0100);
        chk_resp("t2_i");
        i_req = 1'b0;
        tick();
        i_req = 1'b1;
        d_req = 1'b1;
        tick();
        run_burst("t2_d2", 1'b1, 32'h4000_0040);
        i_req = 1'b0;
        d_req = 1'b0;
        tick();
        tick();
        mem_ack = 1'b0;

        // byte store with three wait cycles; inputs changed after grant
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h0000_0103;
        d_size  = SIZE_BYTE;
        d_wdata = 32'h0000_00AB;
        tick();
        d_addr  = 32'h0000_0999;
        d_wdata = 32'h1234_5678;
        d_size  = SIZE_WORD;
        for (int w = 0; w < 3; w++) begin
            #1;
            chk("t3_req",   32'(mem_req),  32'd1);
            chk("t3_we",    32'(mem_we),   32'd1);
            chk("t3_addr",  mem_addr,      32'h0000_0103);
            chk("t3_size",  32'(mem_size), 32'(SIZE_BYTE));
            chk("t3_wdata", mem_wdata,     32'h0000_00AB);
            chk("t3_nodone", 32'(d_done),  32'd0);
            tick();
        end
        mem_ack = 1'b1;
        #1;
        chk("t3_done",  32'(d_done), 32'd1);
        chk("t3_addr4", mem_addr,    32'h0000_0103);
        tick();
        chk_resp("t3");
        chk("t3_resp_we", 32'(mem_we), 32'd0);
        d_req   = 1'b0;
        d_we    = 1'b0;
        mem_ack = 1'b0;
        tick();

        // reset on beat 4 of an I burst
        i_req   = 1'b1;
        i_addr  = 32'h0000_2000;
        mem_ack = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) tick();
        #1;
        chk("t4_beat4_addr", mem_addr, 32'h0000_2010);
        RESET = 1'b1;
        #1;
        chk("t4_rst_req",   32'(mem_req),  32'd0);
        chk("t4_rst_busy",  32'(busy),     32'd0);
        chk("t4_rst_done",  32'(i_done),   32'd0);
        chk("t4_rst_valid", 32'(i_rvalid), 32'd0);
        tick();
        RESET = 1'b0;
        tick();
        run_burst("t4_restart", 1'b0, 32'h0000_2000);
        i_req = 1'b0;
        tick();
        mem_ack = 1'b0;

        // gapped acks, request dropped at beat 2, acks in RESP and IDLE
        i_req  = 1'b1;
        i_addr = 32'h0000_3004;
        tick();
        b = 0;
        for (int c = 0; c < 24 && b < 8; c++) begin
            mem_ack   = (c % 3) != 2;
            mem_rdata = 32'h5500_0000 + 32'(c);
            #1;
            chk("t5_addr",   mem_addr, 32'h0000_3000 + 32'(4 * b));
            chk("t5_rvalid", 32'(i_rvalid), 32'(mem_ack));
            chk("t5_done",   32'(i_done), (mem_ack && b == 7) ? 32'd1 : 32'd0);
            if (mem_ack) b++;
            if (b == 2) i_req = 1'b0;
            tick();
        end
        chk("t5_beats", 32'(b), 32'd8);
        mem_ack = 1'b1;
        chk_resp("t5");
        tick();
        #1;
        chk("t5_idle_busy",   32'(busy),     32'd0);
        chk("t5_idle_rvalid", 32'(i_rvalid), 32'd0);
        chk("t5_idle_req",    32'(mem_req),  32'd0);
        tick();
        #1;
        chk("t5_idle2_busy", 32'(busy), 32'd0);
        i_req  = 1'b1;
        i_addr = 32'h0000_3000;
        tick();
        i_req = 1'b0;
        run_burst("t5_next", 1'b0, 32'h0000_3000);
        tick();
        mem_ack = 1'b0;
        #1;
        chk("end_busy", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
